// File: rtl/eth_rx_pkt_checker.sv
// Receive-side frame checker for a 512-bit AXI-Stream MAC interface: validates
// keep shape, incrementing byte pattern, length, MAC user flag and frame sequence.
//
// state  | meaning
// S_IDLE | waiting for beat 0 of a frame
// S_BODY | beat 0 accepted, waiting for the remaining beats up to last
module eth_rx_pkt_checker #(
  parameter int P_MIN_LEN = 64,
  parameter int P_MAX_LEN = 9600
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [511:0] i_rx_axis_data,
  input  logic [63:0]  i_rx_axis_keep,
  input  logic         i_rx_axis_valid,
  input  logic         i_rx_axis_last,
  input  logic         i_rx_axis_user,
  input  logic         i_clear,
  output logic [31:0]  o_frame_cnt,
  output logic [31:0]  o_err_cnt,
  output logic [47:0]  o_byte_cnt,
  output logic [15:0]  o_last_len,
  output logic         o_err_pulse,
  output logic [4:0]   o_err_type,
  output logic         o_locked
);

  typedef enum logic {S_IDLE, S_BODY} state_t;

  localparam logic [15:0] MIN_LEN = 16'(P_MIN_LEN);
  localparam logic [15:0] MAX_LEN = 16'(P_MAX_LEN);

  state_t      state_q, state_d;

  logic [1:0]  beat_q;
  logic [7:0]  seq_q;
  logic        keep_err_q;
  logic        pat_err_q;
  logic [15:0] len_q;

  logic [31:0] frame_cnt_q;
  logic [31:0] err_cnt_q;
  logic [47:0] byte_cnt_q;
  logic [15:0] last_len_q;
  logic        err_pulse_q;
  logic [4:0]  err_type_q;
  logic        locked_q;
  logic [7:0]  exp_seq_q;

  logic        first_beat;
  logic [7:0]  seq_cur;
  logic [1:0]  beat_cur;
  logic [6:0]  kept;
  logic        pat_bad;
  logic        keep_ok;
  logic [16:0] len_sum;
  logic [15:0] len_cur;
  logic        f_keep;
  logic        f_pat;
  logic        f_len;
  logic        f_seq;
  logic [4:0]  err_vec;
  logic        frame_end;
  logic [31:0] frame_cnt_inc;
  logic [31:0] err_cnt_inc;
  logic [48:0] byte_sum;
  logic [47:0] byte_cnt_add;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (i_rx_axis_valid && !i_rx_axis_last) state_d = S_BODY;
      S_BODY: if (i_rx_axis_valid && i_rx_axis_last)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Only the beat index mod 4 matters: 64*b wraps modulo 256 every four beats.
  always_comb begin
    first_beat = (state_q == S_IDLE);
    seq_cur    = first_beat ? i_rx_axis_data[7:0] : seq_q;
    beat_cur   = first_beat ? 2'd0 : beat_q;
    kept       = '0;
    pat_bad    = 1'b0;
    for (int j = 0; j < 64; j++) begin
      if (i_rx_axis_keep[j]) begin
        kept = kept + 7'd1;
        if (i_rx_axis_data[8*j +: 8] != seq_cur + {beat_cur, 6'd0} + 8'(j))
          pat_bad = 1'b1;
      end
    end
  end

  always_comb begin
    if (i_rx_axis_last)
      keep_ok = (i_rx_axis_keep != '0) &&
                ((i_rx_axis_keep & (i_rx_axis_keep + 64'd1)) == '0);
    else
      keep_ok = &i_rx_axis_keep;
    len_sum   = {1'b0, (first_beat ? 16'd0 : len_q)} + 17'(kept);
    len_cur   = len_sum[16] ? 16'hFFFF : len_sum[15:0];
    f_keep    = (!first_beat && keep_err_q) || !keep_ok;
    f_pat     = (!first_beat && pat_err_q) || pat_bad;
    f_len     = (len_cur < MIN_LEN) || (len_cur > MAX_LEN);
    f_seq     = locked_q && (seq_cur != exp_seq_q);
    err_vec   = {f_seq, i_rx_axis_user, f_len, f_keep, f_pat};
    frame_end = i_rx_axis_valid && i_rx_axis_last;
  end

  always_comb begin
    frame_cnt_inc = (&frame_cnt_q) ? frame_cnt_q : frame_cnt_q + 32'd1;
    err_cnt_inc   = (&err_cnt_q) ? err_cnt_q : err_cnt_q + 32'd1;
    byte_sum      = {1'b0, byte_cnt_q} + 49'(len_cur);
    byte_cnt_add  = byte_sum[48] ? '1 : byte_sum[47:0];
  end

  // Per-frame accumulators; untouched by i_clear so a frame in flight survives it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      beat_q     <= '0;
      seq_q      <= '0;
      keep_err_q <= 1'b0;
      pat_err_q  <= 1'b0;
      len_q      <= '0;
    end else if (i_rx_axis_valid) begin
      beat_q     <= beat_cur + 2'd1;
      seq_q      <= seq_cur;
      keep_err_q <= f_keep;
      pat_err_q  <= f_pat;
      len_q      <= len_cur;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      last_len_q  <= '0;
      err_pulse_q <= 1'b0;
      err_type_q  <= '0;
      locked_q    <= 1'b0;
      exp_seq_q   <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      if (frame_end) last_len_q <= len_cur;
      if (i_clear) begin
        frame_cnt_q <= '0;
        err_cnt_q   <= '0;
        byte_cnt_q  <= '0;
        err_type_q  <= '0;
        locked_q    <= 1'b0;
        exp_seq_q   <= '0;
      end else if (frame_end) begin
        exp_seq_q <= seq_cur + 8'd1;
        if (err_vec[3:0] == '0) locked_q <= 1'b1;
        if (err_vec == '0) begin
          frame_cnt_q <= frame_cnt_inc;
          byte_cnt_q  <= byte_cnt_add;
        end else begin
          err_cnt_q   <= err_cnt_inc;
          err_pulse_q <= 1'b1;
          err_type_q  <= err_type_q | err_vec;
        end
      end
    end
  end

  assign o_frame_cnt = frame_cnt_q;
  assign o_err_cnt   = err_cnt_q;
  assign o_byte_cnt  = byte_cnt_q;
  assign o_last_len  = last_len_q;
  assign o_err_pulse = err_pulse_q;
  assign o_err_type  = err_type_q;
  assign o_locked    = locked_q;

endmodule

// File: tb/tb_eth_rx_pkt_checker.sv
// Bench for eth_rx_pkt_checker: frames built as byte sequences, a frame-level
// reference model feeds a scoreboard that a negedge monitor drains.
`timescale 1ns/1ps
module tb_eth_rx_pkt_checker;
  localparam int MIN_L = 64;
  localparam int MAX_L = 256;
  localparam int MAXB  = 8;

  logic         clk = 1'b0;
  logic         rst, clr;
  logic [511:0] data;
  logic [63:0]  keep;
  logic         valid, last, user;
  logic [31:0]  frame_cnt, err_cnt;
  logic [47:0]  byte_cnt;
  logic [15:0]  last_len;
  logic         err_pulse;
  logic [4:0]   err_type;
  logic         locked;

  eth_rx_pkt_checker #(.P_MIN_LEN(MIN_L), .P_MAX_LEN(MAX_L)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_rx_axis_data(data), .i_rx_axis_keep(keep), .i_rx_axis_valid(valid),
    .i_rx_axis_last(last), .i_rx_axis_user(user), .i_clear(clr),
    .o_frame_cnt(frame_cnt), .o_err_cnt(err_cnt), .o_byte_cnt(byte_cnt),
    .o_last_len(last_len), .o_err_pulse(err_pulse), .o_err_type(err_type),
    .o_locked(locked)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] fc;
    logic [31:0] ec;
    logic [47:0] bc;
    logic [15:0] ll;
    logic [4:0]  et;
    logic        lk;
    logic        pulse;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  logic [31:0] m_fc, m_ec;
  logic [47:0] m_bc;
  logic [15:0] m_ll;
  logic [4:0]  m_et;
  logic        m_lk;
  logic [7:0]  m_exp;

  logic [511:0] fd[MAXB];
  logic [63:0]  fk[MAXB];
  int           fn;
  logic         fuser;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic m_clear();
    m_fc = '0; m_ec = '0; m_bc = '0; m_et = '0; m_lk = 1'b0; m_exp = '0;
  endtask

  task automatic m_reset();
    m_clear();
    m_ll = '0;
  endtask

  // Frame of len bytes whose k-th byte is (s + k) mod 256; unkept lanes hold noise.
  task automatic build(input logic [7:0] s, input int len);
    fn = (len + 63) / 64;
    fuser = 1'b0;
    for (int b = 0; b < fn; b++)
      for (int j = 0; j < 64; j++) begin
        int idx;
        idx = 64 * b + j;
        fd[b][8*j +: 8] = (idx < len) ? 8'(int'(s) + idx) : 8'($urandom);
        fk[b][j] = (idx < len);
      end
  endtask

  task automatic model_frame(input bit c, output exp_t e);
    logic [7:0] s;
    int len, k;
    bit pat, kb, le, sq;
    logic [4:0] errs;
    logic [15:0] lenc;
    s = fd[0][7:0];
    len = 0; pat = 0; kb = 0;
    for (int b = 0; b < fn; b++)
      for (int j = 0; j < 64; j++)
        if (fk[b][j]) begin
          len++;
          if (fd[b][8*j +: 8] != 8'(int'(s) + 64 * b + j)) pat = 1;
        end
    for (int b = 0; b < fn - 1; b++)
      if (fk[b] != {64{1'b1}}) kb = 1;
    k = 0;
    while (k < 64 && fk[fn-1][k]) k++;
    if (k == 0) kb = 1;
    for (int j = k; j < 64; j++) if (fk[fn-1][j]) kb = 1;
    lenc = (len > 65535) ? 16'hFFFF : 16'(len);
    le = (lenc < MIN_L) || (lenc > MAX_L);
    sq = m_lk && (s != m_exp);
    errs = {sq, fuser, le, kb, pat};
    e.pulse = 1'b0;
    m_ll = lenc;
    if (c) m_clear();
    else begin
      m_exp = s + 8'd1;
      if (errs[3:0] == 0) m_lk = 1'b1;
      if (errs == 0) begin
        if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
        m_bc = (m_bc + 48'(lenc) < m_bc) ? {48{1'b1}} : m_bc + 48'(lenc);
      end else begin
        if (m_ec != 32'hFFFF_FFFF) m_ec = m_ec + 1;
        m_et = m_et | errs;
        e.pulse = 1'b1;
      end
    end
    e.fc = m_fc; e.ec = m_ec; e.bc = m_bc; e.ll = m_ll; e.et = m_et; e.lk = m_lk;
  endtask

  task automatic put(input logic v, input logic [511:0] d, input logic [63:0] k,
                     input logic l, input logic u, input logic c);
    @(posedge clk); #1;
    valid = v; data = d; keep = k; last = l; user = u; clr = c;
  endtask

  task automatic idle();
    put(1'b0, {16{$urandom}}, {$urandom, $urandom}, 1'($urandom), 1'($urandom), 1'b0);
  endtask

  task automatic do_clear();
    put(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    m_clear();
  endtask

  task automatic drive(input int clr_beat, input int gap_pct);
    exp_t e;
    for (int b = 0; b < fn; b++) begin
      while ($urandom_range(0, 99) < gap_pct) idle();
      if (b == fn - 1) begin
        model_frame(b == clr_beat, e);
        sb.push_back(e);
        put(1'b1, fd[b], fk[b], 1'b1, fuser, b == clr_beat);
      end else begin
        if (b == clr_beat) m_clear();
        put(1'b1, fd[b], fk[b], 1'b0, 1'($urandom), b == clr_beat);
      end
    end
  endtask

  // Monitor: one cycle after an accepted last beat, compare against the scoreboard.
  bit pend = 1'b0;
  always @(negedge clk) begin
    if (pend) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_empty: frame end seen with no expected entry at %0t", $time);
      end else begin
        mon_e = sb.pop_front();
        chk("frame_cnt", 64'(frame_cnt), 64'(mon_e.fc));
        chk("err_cnt",   64'(err_cnt),   64'(mon_e.ec));
        chk("byte_cnt",  64'(byte_cnt),  64'(mon_e.bc));
        chk("last_len",  64'(last_len),  64'(mon_e.ll));
        chk("err_type",  64'(err_type),  64'(mon_e.et));
        chk("locked",    64'(locked),    64'(mon_e.lk));
        chk("err_pulse", 64'(err_pulse), 64'(mon_e.pulse));
      end
    end else begin
      chk("err_pulse_idle", 64'(err_pulse), 64'd0);
    end
    pend = valid && last && !rst;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s;
    int len;
    rst = 1'b1; clr = 1'b0; valid = 1'b0; data = '0; keep = '0; last = 1'b0; user = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("rst_err_cnt",   64'(err_cnt),   64'd0);
    chk("rst_byte_cnt",  64'(byte_cnt),  64'd0);
    chk("rst_last_len",  64'(last_len),  64'd0);
    chk("rst_err_type",  64'(err_type),  64'd0);
    chk("rst_locked",    64'(locked),    64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Two good 128-byte frames.
    build(8'h00, 128); drive(-1, 0);
    build(8'h01, 128); drive(-1, 20);
    idle();

    // Good 100-byte frame (short last beat), then a 60-byte runt.
    do_clear();
    build(8'h33, 100); drive(-1, 0);
    build(8'h34, 60);  drive(-1, 0);
    idle();

    // Locked at 0x05, out-of-order 0x07, then resync at 0x08.
    do_clear();
    build(8'h04, 64); drive(-1, 0);
    build(8'h07, 64); drive(-1, 0);
    build(8'h08, 64); drive(-1, 0);
    idle();

    // Pattern error in beat 1 byte 10, then a user-flagged frame.
    do_clear();
    build(8'h10, 128); fd[1][8*10 +: 8] = 8'h4A; drive(-1, 0);
    build(8'h11, 64); fuser = 1'b1; drive(-1, 0);
    idle();

    // Reset during beat 1 of a 3-beat frame, then a fresh 64-byte frame.
    build(8'h40, 192);
    put(1'b1, fd[0], fk[0], 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1; valid = 1'b1; data = fd[1]; keep = fk[1]; last = 1'b0;
    m_reset();
    @(negedge clk);
    chk("midrst_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("midrst_locked",    64'(locked),    64'd0);
    @(posedge clk); #1 rst = 1'b0; valid = 1'b0;
    build(8'h20, 64); drive(-1, 0);
    idle();

    // Back-to-back single-beat frames 0..9, then 0x0A must still be in sequence.
    do_clear();
    for (int i = 0; i < 10; i++) begin
      build(8'(i), 64); drive(-1, 0);
    end
    build(8'h0A, 64); drive(-1, 0);
    idle();

    // Clear mid-frame (frame still counts) and clear on the last beat (discarded).
    build(8'h0B, 192); drive(1, 0);
    build(8'h50, 128); drive(1, 0);
    build(8'h60, 64);  drive(-1, 0);
    idle();

    for (int n = 0; n < 150; n++) begin
      s = (m_lk && $urandom_range(0, 9) != 0) ? m_exp : 8'($urandom);
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 300) : $urandom_range(MIN_L, MAX_L);
      build(s, len);
      if ($urandom_range(0, 9) == 0) begin
        int b;
        b = $urandom_range(0, fn - 1);
        fd[b][$urandom_range(0, 511)] ^= 1'b1;
      end
      if ($urandom_range(0, 19) == 0) begin
        int b;
        b = $urandom_range(0, fn - 1);
        fk[b][$urandom_range(0, 63)] ^= 1'b1;
      end
      fuser = ($urandom_range(0, 9) == 0);
      drive(($urandom_range(0, 29) == 0) ? $urandom_range(0, fn - 1) : -1,
            ($urandom_range(0, 1) == 0) ? 0 : 30);
    end

    repeat (4) idle();
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_rx_pkt_checker.md
ETH_RX_PKT_CHECKER -- requirements
Module: eth_rx_pkt_checker

Interface
REQ-001 SHALL have parameter P_MIN_LEN, default 64, minimum legal frame length in bytes.
REQ-002 SHALL have parameter P_MAX_LEN, default 9600, maximum legal frame length in bytes.
REQ-003 i_clk  input  1  single clock; all logic on rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_rx_axis_data  input  512  receive beat; byte j at bits [8j+7:8j].
REQ-006 i_rx_axis_keep  input  64  byte enables, bit j qualifies byte j.
REQ-007 i_rx_axis_valid  input  1  beat valid; always accepted (no ready).
REQ-008 i_rx_axis_last  input  1  final beat of frame.
REQ-009 i_rx_axis_user  input  1  MAC bad-frame flag, sampled on last beat only.
REQ-010 i_clear  input  1  synchronous clear of all counters and lock.
REQ-011 o_frame_cnt  output  32  good frames received.
REQ-012 o_err_cnt  output  32  errored frames received.
REQ-013 o_byte_cnt  output  48  bytes in good frames.
REQ-014 o_last_len  output  16  byte length of most recent frame (good or bad).
REQ-015 o_err_pulse  output  1  one-cycle pulse when a frame completes with error.
REQ-016 o_err_type  output  5  sticky error bits {seq, user, len, keep, pattern}.
REQ-017 o_locked  output  1  high once a good frame has set the expected sequence.

Function
REQ-018 Expected pattern: byte j of beat b of a frame with sequence s SHALL equal (s + 64*b + j) mod 256; s is byte 0 of beat 0.
REQ-019 FSM states SHALL be S_IDLE (await first beat) and S_BODY (inside frame); valid in S_IDLE -> S_BODY unless last also high (single-beat frame stays S_IDLE).
REQ-020 S_BODY -> S_IDLE on valid&last; cycles without valid SHALL hold state and all accumulators.
REQ-021 Keep check: non-last beats require keep = all ones; last beat requires keep contiguous from bit 0 and nonzero; violation sets frame keep error.
REQ-022 Pattern check SHALL compare only kept bytes; any mismatch sets frame pattern error.
REQ-023 Length = sum of kept bytes across frame, 16-bit saturating; length < P_MIN_LEN or > P_MAX_LEN sets length error.
REQ-024 i_rx_axis_user high on last beat sets user error.
REQ-025 Sequence check: when o_locked, s SHALL equal expected; mismatch sets seq error; expected SHALL always update to s+1 mod 256 at frame end (resync).
REQ-026 o_locked SHALL set at end of first frame with no non-seq errors; remains set until reset or i_clear.
REQ-027 Per frame at most one count: error-free -> o_frame_cnt+1 and o_byte_cnt+length; else o_err_cnt+1, o_err_pulse=1, error bits OR'd into o_err_type.
REQ-028 All frame-end outputs SHALL update exactly one cycle after the last beat is accepted.
REQ-029 Counters SHALL saturate at all ones, never wrap.
REQ-030 Back-to-back frames (last followed immediately by next first beat) SHALL be checked with no lost beat.
REQ-031 i_clear SHALL zero counters, o_err_type, o_locked, expected seq; in-progress frame continues and is counted normally at its end.
REQ-032 i_clear coincident with a frame-end update: clear SHALL win, then that frame is discarded from counts.

Reset
REQ-033 On i_rst: FSM -> S_IDLE, all counters, o_last_len, o_err_type, o_err_pulse, o_locked, expected seq and frame accumulators = 0, immediately and asynchronously.
REQ-034 Reset mid-frame SHALL abandon the frame; first valid beat after release is treated as beat 0 of a new frame.

Verification
REQ-035 Two 128-byte frames s=0x00, s=0x01, all keep set -> o_frame_cnt=2, o_byte_cnt=256, o_locked=1, o_err_cnt=0, o_last_len=128.
REQ-036 100-byte frame (last keep=0x0000_000F_FFFF_FFFF) then 60-byte frame -> frame_cnt=1, err_cnt=1, o_err_type=5'b00100, one o_err_pulse.
REQ-037 Locked at expected 0x05, frame arrives with s=0x07 -> err_cnt+1, o_err_type bit4 set; next frame s=0x08 counts good.
REQ-038 Byte 10 of beat 1 corrupted (0x4A != expected) -> pattern error, o_err_type=5'b00001; user=1 on last of following frame -> bit3 set.
REQ-039 i_rst asserted during beat 1 of 3-beat frame, released, new 64-byte frame s=0x20 -> frame_cnt=1, byte_cnt=64, no error.
REQ-040 Back-to-back 64-byte single-beat frames s=0..9 with valid continuously high -> frame_cnt=10 one cycle after final beat, expected seq=0x0A.
